// File: rtl/operand_seq_pkg.sv
// Shared types and constants for the operand sequencer slice.
package operand_seq_pkg;

   localparam int unsigned OPCODE_W = 2;

   typedef enum logic [1:0] {
      WAIT_A  = 2'd0,
      WAIT_B  = 2'd1,
      WAIT_OP = 2'd2,
      SHOW    = 2'd3
   } state_t;

endpackage

// File: rtl/load_reg.sv
// Width-parameterized register with synchronous reset and load enable.
module load_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/operand_sequencer.sv
// Steps through operand A, operand B and opcode entry, then shows the result;
// supports undo and aborts back to WAIT_A after too long idle mid-sequence.
module operand_sequencer
   import operand_seq_pkg::*;
#(
   parameter int unsigned N       = 16,
   parameter int unsigned TIMEOUT = 100_000_000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enter,
   input  logic            undo,
   input  logic [N-1:0]    data_in,
   output logic [N-1:0]    op_a,
   output logic [N-1:0]    op_b,
   output logic [1:0]      opcode,
   output logic            load_a,
   output logic            load_b,
   output logic            load_op,
   output logic [1:0]      state_id,
   output logic            result_valid,
   output logic [7:0]      ops_done
);

   localparam int unsigned CW = $clog2(TIMEOUT);
   // Abort fires on the idle edge that would bring the count to TIMEOUT-1.
   localparam logic [CW-1:0] IDLE_LIMIT = CW'(TIMEOUT - 2);

   state_t          state, state_nx;
   logic [CW-1:0]   idle_cnt, idle_nx;
   logic            go, back, waiting;

   assign go      = enter & ~undo;
   assign back    = undo & ~enter;
   assign waiting = (state == WAIT_B) || (state == WAIT_OP);

   always_comb begin
      state_nx = state;
      load_a   = 1'b0;
      load_b   = 1'b0;
      load_op  = 1'b0;
      idle_nx  = '0;
      if (!reset) begin
         if (go) begin
            case (state)
               WAIT_A:  begin state_nx = WAIT_B;  load_a  = 1'b1; end
               WAIT_B:  begin state_nx = WAIT_OP; load_b  = 1'b1; end
               WAIT_OP: begin state_nx = SHOW;    load_op = 1'b1; end
               default: state_nx = WAIT_A;
            endcase
         end else if (back) begin
            case (state)
               WAIT_B:  state_nx = WAIT_A;
               WAIT_OP: state_nx = WAIT_B;
               SHOW:    state_nx = WAIT_OP;
               default: state_nx = state;
            endcase
         end else if (!enter && waiting) begin
            if (idle_cnt == IDLE_LIMIT)
               state_nx = WAIT_A;
            else
               idle_nx = idle_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= WAIT_A;
         idle_cnt <= '0;
         ops_done <= '0;
      end else begin
         state    <= state_nx;
         idle_cnt <= idle_nx;
         if (load_op)
            ops_done <= ops_done + 8'd1;
      end
   end

   load_reg #(.W(N)) u_reg_a (
      .clk   (clk),
      .reset (reset),
      .load  (load_a),
      .d     (data_in),
      .q     (op_a)
   );

   load_reg #(.W(N)) u_reg_b (
      .clk   (clk),
      .reset (reset),
      .load  (load_b),
      .d     (data_in),
      .q     (op_b)
   );

   load_reg #(.W(OPCODE_W)) u_reg_op (
      .clk   (clk),
      .reset (reset),
      .load  (load_op),
      .d     (data_in[OPCODE_W-1:0]),
      .q     (opcode)
   );

   assign state_id     = state;
   assign result_valid = (state == SHOW) && !reset;

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter N, default 16, operand width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 100_000_000, idle cycles allowed in WAIT_B/WAIT_OP before abort; legal range >= 2.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enter  input  1  single-cycle pulse: accept data_in for current state.
REQ-006 SHALL have port undo  input  1  single-cycle pulse: step back one state.
REQ-007 SHALL have port data_in  input  N  operand/opcode source; opcode taken from data_in[1:0].
REQ-008 SHALL have port op_a  output  N  stored operand A.
REQ-009 SHALL have port op_b  output  N  stored operand B.
REQ-010 SHALL have port opcode  output  2  stored opcode.
REQ-011 SHALL have port load_a, load_b, load_op  output  1 each  one-cycle load strobes.
REQ-012 SHALL have port state_id  output  2  current state encoding.
REQ-013 SHALL have port result_valid  output  1  high while in SHOW.
REQ-014 SHALL have port ops_done  output  8  count of completed sequences.

Function
REQ-015 SHALL implement states WAIT_A=0, WAIT_B=1, WAIT_OP=2, SHOW=3, driven on state_id.
REQ-016 SHALL, on enter alone: WAIT_A->WAIT_B with load_a; WAIT_B->WAIT_OP with load_b; WAIT_OP->SHOW with load_op; SHOW->WAIT_A with no strobe.
REQ-017 SHALL drive load strobes combinationally from (state, enter) so op_a/op_b/opcode update on the same edge the state advances; new value visible the cycle after enter.
REQ-018 SHALL, on undo alone: WAIT_B->WAIT_A, WAIT_OP->WAIT_B, SHOW->WAIT_OP; undo in WAIT_A ignored; no stored value changes on undo.
REQ-019 SHALL ignore enter and undo asserted in the same cycle (no transition, no strobe).
REQ-020 SHALL retain op_a/op_b/opcode until the next corresponding load; returning to WAIT_A does not clear them.
REQ-021 SHALL assert result_valid exactly while state is SHOW.
REQ-022 SHALL increment ops_done on the WAIT_OP->SHOW transition, wrapping 255->0.
REQ-023 SHALL count idle cycles in WAIT_B and WAIT_OP; counter clears on any state change, enter or undo; when count reaches TIMEOUT-1 without enter/undo, next state is WAIT_A, stored values untouched.
REQ-024 SHALL never time out in WAIT_A or SHOW.
REQ-025 SHALL assert at most one load strobe per cycle.

Reset
REQ-026 SHALL on reset set state WAIT_A, op_a=0, op_b=0, opcode=0, ops_done=0, idle counter=0.
REQ-027 SHALL hold all load strobes low and result_valid low during reset, overriding enter/undo.
REQ-028 SHALL abandon any partial sequence when reset is asserted mid-operation.

Structure
REQ-029 SHALL place the state enum type and the opcode width constant (2) in a shared package operand_seq_pkg.
REQ-030 SHALL instantiate three copies of sub-module load_reg (parameterized width, synchronous reset, load enable) for op_a (N), op_b (N) and opcode (2).
REQ-031 SHALL size the idle counter as $clog2(TIMEOUT) bits.

Verification
REQ-032 SHALL cover full sequence: data_in=0x0012 enter, 0x0034 enter, 0x0001 enter -> op_a=0x0012, op_b=0x0034, opcode=1, result_valid=1, ops_done=1.
REQ-033 SHALL cover undo: in WAIT_OP undo -> WAIT_B, op_b unchanged; enter with 0x00FF -> op_b=0x00FF, state WAIT_OP.
REQ-034 SHALL cover simultaneous enter+undo in WAIT_B -> state stays 1, no strobe; undo in WAIT_A -> state stays 0.
REQ-035 SHALL cover timeout with TIMEOUT=8: enter in WAIT_A, then 7 idle cycles -> state WAIT_A, op_a retained.
REQ-036 SHALL cover wrap: 256 complete sequences -> ops_done=0; reset asserted in WAIT_OP -> all outputs 0, state WAIT_A next cycle.
